// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: two buffered writeback sources (ALU, load),
// age-aware round-robin grant, $zero discard and a pending-write hazard vector.
module rf_write_arbiter #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [AW-1:0]    alu_addr,
  input  logic [DW-1:0]    alu_data,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [AW-1:0]    mem_addr,
  input  logic [DW-1:0]    mem_data,
  output logic             rf_load,
  output logic [AW-1:0]    rf_caddr,
  output logic [DW-1:0]    rf_c,
  output logic [2**AW-1:0] pending,
  output logic [7:0]       drop_cnt
);

  logic          alu_full_q, alu_full_d;
  logic [AW-1:0] alu_addr_q, alu_addr_d;
  logic [DW-1:0] alu_data_q, alu_data_d;
  logic          mem_full_q, mem_full_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_data_q, mem_data_d;
  logic          mem_older_q, mem_older_d;
  logic          last_grant_q, last_grant_d;  // 1 = mem was granted last
  logic          rf_load_q, rf_load_d;
  logic [AW-1:0] rf_caddr_q, rf_caddr_d;
  logic [DW-1:0] rf_c_q, rf_c_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic gnt_alu, gnt_mem, alu_xfer, mem_xfer;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;
  logic [2**AW-1:0] pending_v;

  // Same-address contention goes to the older entry so the younger write lands last.
  always_comb begin
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    if (alu_full_q && mem_full_q) begin
      if (alu_addr_q == mem_addr_q) begin
        gnt_mem = mem_older_q;
        gnt_alu = !mem_older_q;
      end else begin
        gnt_mem = !last_grant_q;
        gnt_alu = last_grant_q;
      end
    end else begin
      gnt_alu = alu_full_q;
      gnt_mem = mem_full_q;
    end
  end

  assign alu_ready = !alu_full_q || gnt_alu;
  assign mem_ready = !mem_full_q || gnt_mem;
  assign alu_xfer  = alu_valid && alu_ready;
  assign mem_xfer  = mem_valid && mem_ready;
  assign win_addr  = gnt_mem ? mem_addr_q : alu_addr_q;
  assign win_data  = gnt_mem ? mem_data_q : alu_data_q;

  always_comb begin
    alu_full_d   = alu_full_q && !gnt_alu;
    alu_addr_d   = alu_addr_q;
    alu_data_d   = alu_data_q;
    mem_full_d   = mem_full_q && !gnt_mem;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_older_d  = mem_older_q;
    last_grant_d = last_grant_q;
    rf_load_d    = 1'b0;
    rf_caddr_d   = rf_caddr_q;
    rf_c_d       = rf_c_q;
    drop_cnt_d   = drop_cnt_q;
    if (alu_xfer) begin
      alu_full_d = 1'b1;
      alu_addr_d = alu_addr;
      alu_data_d = alu_data;
    end
    if (mem_xfer) begin
      mem_full_d = 1'b1;
      mem_addr_d = mem_addr;
      mem_data_d = mem_data;
    end
    // Age only matters when both end up full; a simultaneous fill counts mem as older.
    if (mem_xfer && (alu_xfer || (alu_full_q && !gnt_alu)))
      mem_older_d = 1'b1;
    else if (alu_xfer && mem_full_q && !gnt_mem)
      mem_older_d = 1'b0;
    if (gnt_alu || gnt_mem) begin
      last_grant_d = gnt_mem;
      rf_caddr_d   = win_addr;
      rf_c_d       = win_data;
      rf_load_d    = (win_addr != '0);
      if (win_addr == '0 && drop_cnt_q != 8'hFF)
        drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_full_q   <= 1'b0;
      alu_addr_q   <= '0;
      alu_data_q   <= '0;
      mem_full_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_older_q  <= 1'b0;
      last_grant_q <= 1'b0;
      rf_load_q    <= 1'b0;
      rf_caddr_q   <= '0;
      rf_c_q       <= '0;
      drop_cnt_q   <= 8'd0;
    end else begin
      alu_full_q   <= alu_full_d;
      alu_addr_q   <= alu_addr_d;
      alu_data_q   <= alu_data_d;
      mem_full_q   <= mem_full_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_older_q  <= mem_older_d;
      last_grant_q <= last_grant_d;
      rf_load_q    <= rf_load_d;
      rf_caddr_q   <= rf_caddr_d;
      rf_c_q       <= rf_c_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  always_comb begin
    pending_v = '0;
    if (alu_full_q) pending_v[alu_addr_q] = 1'b1;
    if (mem_full_q) pending_v[mem_addr_q] = 1'b1;
    if (rf_load_q)  pending_v[rf_caddr_q] = 1'b1;
    pending_v[0] = 1'b0;
  end

  assign pending  = pending_v;
  assign rf_load  = rf_load_q;
  assign rf_caddr = rf_caddr_q;
  assign rf_c     = rf_c_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: expected commits are queued as stimulus
// is driven and compared against each rf_load cycle.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [3:0]  alu_addr, mem_addr, rf_caddr;
  logic [15:0] alu_data, mem_data, rf_c, pending;
  logic        rf_load;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit sb_en = 1'b0;
  logic [19:0] sb_q[$];

  rf_write_arbiter #(.DW(16), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_load(rf_load), .rf_caddr(rf_caddr), .rf_c(rf_c),
    .pending(pending), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Commit monitor
  always @(posedge clk) begin
    #1;
    if (sb_en && rst_n && rf_load) begin
      if (sb_q.size() == 0)
        chk("extra_commit", {12'h0, rf_caddr, rf_c}, 32'hFFFF_FFFF);
      else
        chk("commit", {12'h0, rf_caddr, rf_c}, {12'h0, sb_q.pop_front()});
    end
  end

  task automatic drain(input string tag);
    int n = 0;
    while ((sb_q.size() != 0 || rf_load) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sb_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mi, ai, c;
    logic mr, ar;
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    #1;
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_mem_ready", mem_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_rf_load", rf_load, 0);
    chk("rst_caddr_c", {rf_caddr, rf_c}, 0);
    chk("rst_pending", pending, 0);
    chk("rst_drop", drop_cnt, 0);

    // Reset mid-stream
    alu_valid = 1'b1; alu_addr = 4'd0; alu_data = 16'hFFFF;
    @(negedge clk); alu_addr = 4'd3; alu_data = 16'h0001;
    @(negedge clk); alu_addr = 4'd4; alu_data = 16'h0002;
    @(posedge clk); #1;
    chk("mid_pre_load", {rf_load, rf_caddr}, {1'b1, 4'd3});
    chk("mid_pre_drop", drop_cnt, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rf_load", rf_load, 0);
    chk("mid_pending", pending, 0);
    chk("mid_drop", drop_cnt, 0);
    chk("mid_readies", {alu_ready, mem_ready}, 2'b11);
    alu_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_no_write", rf_load, 0);
    end
    sb_q.delete();
    sb_en = 1'b1;

    // Single source back-to-back
    @(negedge clk);
    sb_q.push_back({4'd3, 16'h1234});
    sb_q.push_back({4'd4, 16'h00FF});
    chk("single_rdy0", alu_ready, 1);
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 16'h1234;
    @(negedge clk);
    chk("single_rdy1", alu_ready, 1);
    chk("single_pend", pending, 16'h0008);
    alu_addr = 4'd4; alu_data = 16'h00FF;
    @(negedge clk);
    alu_valid = 1'b0;
    chk("single_load1", {rf_load, rf_caddr}, {1'b1, 4'd3});
    @(negedge clk);
    chk("single_load2", {rf_load, rf_caddr}, {1'b1, 4'd4});
    @(negedge clk);
    chk("single_idle", rf_load, 0);
    drain("drain_single");

    // Contention, different addresses
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back({4'd5, 16'hAAAA + 16'(k)});
      sb_q.push_back({4'd6, 16'h5555 + 16'(k)});
    end
    mem_addr = 4'd5; mem_data = 16'hAAAA; mem_valid = 1'b1;
    alu_addr = 4'd6; alu_data = 16'h5555; alu_valid = 1'b1;
    mi = 0; ai = 0; c = 0;
    while ((mi < 3 || ai < 3) && c < 20) begin
      mr = mem_ready; ar = alu_ready;
      chk("cont_mem_ready", mr, (c == 0) || (c % 2 == 1));
      chk("cont_alu_ready", ar, (c % 2 == 0));
      @(negedge clk);
      if (mem_valid && mr) begin
        mi++;
        if (mi < 3) mem_data = 16'hAAAA + 16'(mi); else mem_valid = 1'b0;
      end
      if (alu_valid && ar) begin
        ai++;
        if (ai < 3) alu_data = 16'h5555 + 16'(ai); else alu_valid = 1'b0;
      end
      c++;
    end
    chk("cont_transfers", mi + ai, 6);
    drain("drain_cont");

    // Same address, mem captured first
    sb_q.push_back({4'd7, 16'h1111});
    sb_q.push_back({4'd7, 16'h2222});
    mem_addr = 4'd7; mem_data = 16'h1111; mem_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    alu_addr = 4'd7; alu_data = 16'h2222; alu_valid = 1'b1;
    @(negedge clk);
    alu_valid = 1'b0;
    drain("drain_same_a");

    // Leave last grant on mem so round-robin alone would pick alu next
    sb_q.push_back({4'd8, 16'h0808});
    mem_addr = 4'd8; mem_data = 16'h0808; mem_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    drain("drain_mem8");

    // Same address, same-edge capture: mem is older
    sb_q.push_back({4'd7, 16'h3333});
    sb_q.push_back({4'd7, 16'h4444});
    mem_addr = 4'd7; mem_data = 16'h3333; mem_valid = 1'b1;
    alu_addr = 4'd7; alu_data = 16'h4444; alu_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0; alu_valid = 1'b0;
    chk("same_b_pend", pending, 16'h0080);
    drain("drain_same_b");

    // Hazard vector
    sb_q.push_back({4'd9, 16'h0909});
    sb_q.push_back({4'd2, 16'h0202});
    mem_addr = 4'd9; mem_data = 16'h0909; mem_valid = 1'b1;
    alu_addr = 4'd2; alu_data = 16'h0202; alu_valid = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0; alu_valid = 1'b0;
    chk("haz_buffered", pending, 16'h0204);
    @(negedge clk);
    chk("haz_inflight", pending, 16'h0204);
    @(negedge clk);
    chk("haz_alu_port", pending, 16'h0004);
    @(negedge clk);
    chk("haz_clear", pending, 16'h0000);
    drain("drain_haz");

    // $zero discard, 300 writes
    alu_addr = 4'd0; alu_data = 16'hFFFF; alu_valid = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      chk("zero_no_load", rf_load, 0);
      chk("zero_pend0", pending[0], 0);
      if (i == 10) chk("zero_drop_mid", drop_cnt, 9);
      if (i == 100) chk("zero_alu_ready", alu_ready, 1);
    end
    alu_valid = 1'b0;
    drain("drain_zero");
    repeat (2) @(negedge clk);
    chk("zero_drop_sat", drop_cnt, 255);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
